// File: rtl/prng_key_sink.sv
// prng_key_sink
//   Consumer end of the split PRNG key stream. The interleaved 128-bit key
//   bus is sampled once per generator half-phase. Samples go into a small
//   show-ahead FIFO, and keys are handed to the AES core over a valid/ready
//   handshake. The block also reports stream health: a sticky overflow flag,
//   a saturating drop counter and a sticky stuck-at detector.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   enable     sampling enable (same net that enables the PRNG)
//   flush      synchronous clear of FIFO and health state
//   key_in     interleaved key bus from the PRNG
//   key_out    head-of-FIFO key (registered)
//   key_valid  key_out holds a valid key (registered)
//   key_ready  AES core accepts key_out this cycle
//   level      FIFO occupancy, 0..DEPTH
//   overflow   sticky: at least one sample was dropped
//   drop_count dropped samples, saturating at all-ones
//   stuck      sticky: STUCK_LIMIT consecutive identical samples seen
module prng_key_sink #(
  parameter int DEPTH       = 4,
  parameter int STUCK_LIMIT = 8,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [127:0]             key_in,
  output logic [127:0]             key_out,
  output logic                     key_valid,
  input  logic                     key_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     stuck
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REP_W = $clog2(STUCK_LIMIT);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(STUCK_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       ph_r;
  logic [127:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [127:0]     key_out_r;
  logic             key_valid_r;
  logic             overflow_r;
  logic [CNT_W-1:0] drop_r;
  logic             stuck_r;
  logic [REP_W-1:0] rep_r;
  logic [127:0]     last_r;
  logic             last_valid_r;

  logic             sample_s;
  logic             pop_s;
  logic             full_s;
  logic             push_s;
  logic             drop_s;
  logic             same_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [LVL_W-1:0] level_nxt_s;
  logic [127:0]     head_nxt_s;
  logic [REP_W-1:0] rep_nxt_s;

  // Handshake, push/drop decision, next pointers/level and next head key.
  always_comb begin
    sample_s     = enable & ph_r[0];
    pop_s        = key_valid_r & key_ready;
    full_s       = (level_r == FULL_LVL);
    // A full FIFO still accepts the sample when the head leaves the same cycle.
    push_s       = sample_s & (~full_s | pop_s);
    drop_s       = sample_s & full_s & ~pop_s;
    rd_ptr_nxt_s = pop_s  ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    wr_ptr_nxt_s = push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
    // The new head is the incoming sample when it lands exactly where the read
    // pointer will point (empty FIFO, or level 1 with a pop): no valid bubble.
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = key_in;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
    same_s = last_valid_r & (key_in == last_r);
    if (same_s) begin
      if (rep_r == REP_MAX) begin
        rep_nxt_s = REP_MAX;
      end else begin
        rep_nxt_s = rep_r + REP_W'(1);
      end
    end else begin
      rep_nxt_s = {REP_W{1'b0}};
    end
  end

  // Half-phase counter tracking the divide-by-4 PRNG clock; flush leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_r <= 2'd0;
    end else if (enable) begin
      ph_r <= ph_r + 2'd1;
    end
  end

  // FIFO storage; contents need no reset because validity lives in level_r.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= key_in;
    end
  end

  // FIFO pointers, occupancy and registered head/valid outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      key_out_r   <= 128'd0;
      key_valid_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      key_out_r   <= 128'd0;
      key_valid_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      level_r     <= level_nxt_s;
      key_out_r   <= head_nxt_s;
      key_valid_r <= (level_nxt_s != {LVL_W{1'b0}});
    end
  end

  // Stream health: sticky overflow, saturating drop count, stuck detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r   <= 1'b0;
      drop_r       <= {CNT_W{1'b0}};
      stuck_r      <= 1'b0;
      rep_r        <= {REP_W{1'b0}};
      last_r       <= 128'd0;
      last_valid_r <= 1'b0;
    end else if (flush) begin
      overflow_r   <= 1'b0;
      drop_r       <= {CNT_W{1'b0}};
      stuck_r      <= 1'b0;
      rep_r        <= {REP_W{1'b0}};
      last_valid_r <= 1'b0;
    end else if (sample_s) begin
      // Dropped samples still feed the stuck detector.
      rep_r        <= rep_nxt_s;
      last_r       <= key_in;
      last_valid_r <= 1'b1;
      if (rep_nxt_s == REP_MAX) begin
        stuck_r <= 1'b1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_r != CNT_MAX) begin
          drop_r <= drop_r + CNT_W'(1);
        end
      end
    end
  end

  assign key_out    = key_out_r;
  assign key_valid  = key_valid_r;
  assign level      = level_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_r;
  assign stuck      = stuck_r;

endmodule

// File: tb/tb_prng_key_sink.sv
// tb_prng_key_sink
//   Self-checking bench for prng_key_sink. A queue-based reference model
//   follows the stream rules (half-phase sampling, bounded FIFO, drops,
//   repeat detection) and is stepped on every clock edge. Directed scenarios
//   check the documented sequences; a randomized run compares every output
//   with the model each cycle.
module tb_prng_key_sink;

  localparam int DEPTH       = 4;
  localparam int STUCK_LIMIT = 8;
  localparam int CNT_W       = 8;
  localparam int LVL_W       = $clog2(DEPTH) + 1;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam logic [127:0] PAT_A5 = {16{8'hA5}};

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic                 flush;
  logic [127:0]         key_in;
  logic [127:0]         key_out;
  logic                 key_valid;
  logic                 key_ready;
  logic [LVL_W-1:0]     level;
  logic                 overflow;
  logic [CNT_W-1:0]     drop_count;
  logic                 stuck;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state
  int           m_ph;
  logic [127:0] m_q[$];
  bit           m_ovf;
  int           m_drop;
  bit           m_stuck;
  int           m_rep;
  logic [127:0] m_last;
  bit           m_last_valid;

  prng_key_sink #(
    .DEPTH(DEPTH), .STUCK_LIMIT(STUCK_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .key_in(key_in), .key_out(key_out), .key_valid(key_valid),
    .key_ready(key_ready), .level(level), .overflow(overflow),
    .drop_count(drop_count), .stuck(stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_ph = 0; m_q.delete(); m_ovf = 0; m_drop = 0; m_stuck = 0;
    m_rep = 0; m_last = 128'd0; m_last_valid = 0;
  endfunction

  // One clock edge of the stream rules, using the inputs present at the edge.
  function automatic void model_step();
    bit smp;
    bit pop;
    smp = enable && (m_ph % 2 == 1);
    pop = (m_q.size() != 0) && key_ready;
    if (enable) m_ph = (m_ph + 1) % 4;
    if (flush) begin
      m_q.delete(); m_ovf = 0; m_drop = 0; m_stuck = 0; m_rep = 0; m_last_valid = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (smp) begin
        if (m_q.size() < DEPTH) m_q.push_back(key_in);
        else begin
          m_ovf = 1;
          if (m_drop < CNT_MAX) m_drop++;
        end
        if (m_last_valid && key_in == m_last) begin
          if (m_rep < STUCK_LIMIT - 1) m_rep++;
        end else m_rep = 0;
        if (m_rep == STUCK_LIMIT - 1) m_stuck = 1;
        m_last = key_in;
        m_last_valid = 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    chk_cnt++; if (key_valid !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", key_valid); else pass_cnt++;
    chk_cnt++; if (level !== LVL_W'(0)) $display("FAIL rst_level: got %0d expected 0", level); else pass_cnt++;
    chk_cnt++; if (key_out !== 128'd0) $display("FAIL rst_key_out: got %0h expected 0", key_out); else pass_cnt++;
    chk_cnt++; if ({overflow, stuck} !== 2'b00) $display("FAIL rst_flags: got %b expected 00", {overflow, stuck}); else pass_cnt++;
    chk_cnt++; if (drop_count !== CNT_W'(0)) $display("FAIL rst_drop: got %0d expected 0", drop_count); else pass_cnt++;
  endtask

  task automatic test_startup();
    reset = 1'b1; enable = 1'b1; key_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      key_in = 128'(i);
      tick();
      if (i == 0) begin
        chk_cnt++; if (key_valid !== 1'b0) $display("FAIL start_no_sample_ph0: got %0b expected 0", key_valid); else pass_cnt++;
      end
      if (i == 1) begin
        chk_cnt++; if (key_valid !== 1'b1 || key_out !== 128'd1) $display("FAIL start_first: got v=%0b k=%0h expected v=1 k=1", key_valid, key_out); else pass_cnt++;
      end
    end
    chk_cnt++; if (level !== LVL_W'(4)) $display("FAIL start_level: got %0d expected 4", level); else pass_cnt++;
    chk_cnt++; if (key_out !== 128'd1) $display("FAIL start_key_out: got %0h expected 1", key_out); else pass_cnt++;
  endtask

  task automatic test_overflow();
    for (int i = 8; i < 14; i++) begin
      key_in = 128'(i);
      tick();
    end
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b expected 1", overflow); else pass_cnt++;
    chk_cnt++; if (drop_count !== CNT_W'(3)) $display("FAIL ovf_drop: got %0d expected 3", drop_count); else pass_cnt++;
    chk_cnt++; if (level !== LVL_W'(4) || key_out !== 128'd1) $display("FAIL ovf_hold: got lvl=%0d k=%0h expected lvl=4 k=1", level, key_out); else pass_cnt++;
  endtask

  task automatic test_full_pop();
    key_in = 128'd14;
    tick();
    key_in = 128'd15; key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk_cnt++; if (level !== LVL_W'(4)) $display("FAIL fullpop_level: got %0d expected 4", level); else pass_cnt++;
    chk_cnt++; if (key_out !== 128'd3) $display("FAIL fullpop_key_out: got %0h expected 3", key_out); else pass_cnt++;
    chk_cnt++; if (drop_count !== CNT_W'(3)) $display("FAIL fullpop_drop: got %0d expected 3", drop_count); else pass_cnt++;
  endtask

  task automatic test_stuck();
    int n;
    int cyc;
    bit smp;
    n = 0; cyc = 0;
    key_ready = 1'b1; key_in = PAT_A5;
    while (n < 8 && cyc < 40) begin
      smp = enable && (m_ph % 2 == 1);
      tick(); cyc++;
      if (smp) begin
        n++;
        if (n == 7) begin
          chk_cnt++; if (stuck !== 1'b0) $display("FAIL stuck_early: got %0b expected 0 after 7th", stuck); else pass_cnt++;
        end
        if (n == 8) begin
          chk_cnt++; if (stuck !== 1'b1) $display("FAIL stuck_8th: got %0b expected 1 after 8th", stuck); else pass_cnt++;
        end
      end
    end
    chk_cnt++; if (n != 8) $display("FAIL stuck_timeout: got %0d samples expected 8", n); else pass_cnt++;
    key_in = 128'h1234_5678;
    repeat (4) tick();
    chk_cnt++; if (stuck !== 1'b1) $display("FAIL stuck_sticky: got %0b expected 1", stuck); else pass_cnt++;
  endtask

  task automatic test_flush();
    int n;
    n = 0;
    key_ready = 1'b0;
    while (!(m_q.size() == 2 && m_ph % 2 == 1) && n < 20) begin
      tick(); n++;
    end
    chk_cnt++; if (level !== LVL_W'(2) || overflow !== 1'b1) $display("FAIL flush_setup: got lvl=%0d ovf=%0b expected lvl=2 ovf=1", level, overflow); else pass_cnt++;
    flush = 1'b1; key_ready = 1'b1; key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
    flush = 1'b0; key_ready = 1'b0;
    chk_cnt++; if (level !== LVL_W'(0) || key_valid !== 1'b0) $display("FAIL flush_fifo: got lvl=%0d v=%0b expected 0/0", level, key_valid); else pass_cnt++;
    chk_cnt++; if ({overflow, stuck} !== 2'b00 || drop_count !== CNT_W'(0)) $display("FAIL flush_health: got ovf=%0b stk=%0b drop=%0d expected 0", overflow, stuck, drop_count); else pass_cnt++;
    tick();
    chk_cnt++; if (level !== LVL_W'(0)) $display("FAIL flush_ph_even: got %0d expected 0", level); else pass_cnt++;
    tick();
    chk_cnt++; if (level !== LVL_W'(1)) $display("FAIL flush_ph_next: got %0d expected 1", level); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n;
    logic [127:0] v;
    n = 0;
    key_ready = 1'b0;
    while (m_q.size() != 3 && n < 20) begin
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick(); n++;
    end
    chk_cnt++; if (level !== LVL_W'(3)) $display("FAIL arst_setup: got %0d expected 3", level); else pass_cnt++;
    #3;
    reset = 1'b0;
    #1;
    chk_cnt++; if (key_valid !== 1'b0 || level !== LVL_W'(0)) $display("FAIL arst_clear: got v=%0b lvl=%0d expected 0/0", key_valid, level); else pass_cnt++;
    chk_cnt++; if (key_out !== 128'd0) $display("FAIL arst_key_out: got %0h expected 0", key_out); else pass_cnt++;
    enable = 1'b0;
    #2;
    model_reset();
    reset = 1'b1;
    repeat (6) begin
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    chk_cnt++; if (level !== LVL_W'(0) || key_valid !== 1'b0) $display("FAIL arst_disabled: got lvl=%0d v=%0b expected 0/0", level, key_valid); else pass_cnt++;
    enable = 1'b1;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_in = v;
    tick();
    tick();
    chk_cnt++; if (level !== LVL_W'(1) || key_out !== v) $display("FAIL arst_resume: got lvl=%0d k=%0h expected 1 k=%0h", level, key_out, v); else pass_cnt++;
  endtask

  task automatic test_saturate();
    flush = 1'b1;
    tick();
    flush = 1'b0; key_ready = 1'b0; enable = 1'b1;
    repeat (540) begin
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    chk_cnt++; if (drop_count !== CNT_W'(CNT_MAX)) $display("FAIL sat_drop: got %0d expected %0d", drop_count, CNT_MAX); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b1 || level !== LVL_W'(4)) $display("FAIL sat_state: got ovf=%0b lvl=%0d expected 1/4", overflow, level); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      enable    = ($urandom_range(0, 3) != 0);
      key_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      chk_cnt++; if (key_valid !== (m_q.size() != 0)) $display("FAIL rnd_valid c%0d: got %0b expected %0b", c, key_valid, m_q.size() != 0); else pass_cnt++;
      chk_cnt++; if (level !== LVL_W'(m_q.size())) $display("FAIL rnd_level c%0d: got %0d expected %0d", c, level, m_q.size()); else pass_cnt++;
      chk_cnt++; if (overflow !== m_ovf) $display("FAIL rnd_ovf c%0d: got %0b expected %0b", c, overflow, m_ovf); else pass_cnt++;
      chk_cnt++; if (drop_count !== CNT_W'(m_drop)) $display("FAIL rnd_drop c%0d: got %0d expected %0d", c, drop_count, m_drop); else pass_cnt++;
      chk_cnt++; if (stuck !== m_stuck) $display("FAIL rnd_stuck c%0d: got %0b expected %0b", c, stuck, m_stuck); else pass_cnt++;
      if (m_q.size() != 0) begin
        chk_cnt++; if (key_out !== m_q[0]) $display("FAIL rnd_key_out c%0d: got %0h expected %0h", c, key_out, m_q[0]); else pass_cnt++;
      end
    end
    flush = 1'b0; key_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; flush = 1'b0; key_ready = 1'b0; key_in = 128'd0;
    model_reset();
    #22;
    test_reset();
    test_startup();
    test_overflow();
    test_full_pop();
    test_stuck();
    test_flush();
    test_async_reset();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/prng_key_sink.md
Name: prng_key_sink

Overview:
- Consumer end of the split PRNG key stream.
- Samples the interleaved 128-bit key bus once per generator half-phase, buffers samples in a small FIFO, and hands keys to the AES core over a valid/ready handshake.
- Also monitors stream health: sticky overflow flag, saturating drop counter, and a stuck detector that fires on repeated identical samples.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- STUCK_LIMIT, 8, number of consecutive identical samples that asserts stuck; at least 2.
- CNT_W, 8, drop counter width.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  sampling enable; same signal that drives the PRNG enable.
- flush  in  1  synchronous clear of FIFO and health state.
- key_in  in  128  interleaved key bus from the PRNG.
- key_out  out  128  head-of-FIFO key.
- key_valid  out  1  key_out holds a valid key.
- key_ready  in  1  AES core accepts key_out this cycle.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; at least one sample was dropped.
- drop_count  out  CNT_W  number of dropped samples; saturates at all-ones.
- stuck  out  1  sticky; STUCK_LIMIT consecutive identical samples seen.

Behaviour:
- Reset (reset low, asynchronous):
  - Phase counter ph[1:0]=0, FIFO pointers=0, level=0, key_valid=0, key_out=0.
  - overflow=0, drop_count=0, stuck=0, repeat count=0, last-sample register=0, last_valid=0.
  - Deassertion of reset takes effect on the next clk edge.
- Phase counter:
  - ph increments by 1 mod 4 on every clk edge while enable=1; holds while enable=0.
- Sample event:
  - Occurs when enable=1 and ph[0]=1 (ph=1 or 3), i.e. once every 2 cycles, mid-way through each generator half-phase of the divide-by-4 PRNG clock.
  - On a sample event, key_in is captured at that clk edge.
- Push:
  - A sample is written to the FIFO if (level<DEPTH) or (level==DEPTH and a pop occurs the same cycle).
  - Otherwise the sample is dropped: overflow<=1, and drop_count increments unless already all-ones.
- Pop:
  - Occurs when key_valid=1 and key_ready=1. rd_ptr advances.
  - key_ready while key_valid=0 is ignored.
- FIFO output:
  - Show-ahead: key_out=mem[rd_ptr] and key_valid=(level!=0), both registered or derived from registered state.
  - A sample pushed into an empty FIFO is visible on key_out/key_valid one cycle after the sampling edge.
- Simultaneous push and pop: level is unchanged. With level==1, key_out moves to the new entry on the following cycle with no valid bubble.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH.
- Stuck detector (evaluated on every sample event, including dropped samples):
  - If last_valid=1 and sample==last sample, repeat count increments, saturating at STUCK_LIMIT-1. Otherwise repeat count=0.
  - last sample<=sample and last_valid<=1.
  - stuck<=1 when repeat count reaches STUCK_LIMIT-1, i.e. on the STUCK_LIMIT-th identical sample. stuck stays set until reset or flush.
  - Stuck samples are still pushed into the FIFO.
- Flush:
  - Has priority over push and pop in the same cycle.
  - Clears pointers, level, overflow, drop_count, stuck, repeat count and last_valid. The sample in that cycle is discarded and not counted.
  - ph is not affected.
- enable low:
  - No sample events occur.
  - Pops continue, and flush still works.
- Reset mid-operation: all FIFO contents are lost immediately. No partial pop is exposed.

Test Plan:
- Startup sampling:
  - Stimulus: release reset, enable=1, key_ready=0, key_in=cycle index.
  - Required: samples captured at ph=1,3 (values 1,3,5,7); level reaches 4 at the 4th sample; key_out=1.
- Overflow:
  - Stimulus: continue from the startup scenario for 3 more sample events.
  - Required: overflow=1, drop_count=3, level=4, key_out still 1.
- Full with concurrent pop:
  - Stimulus: full FIFO, assert key_ready exactly on a sample edge.
  - Required: no drop, level stays 4, key_out=3 next cycle, drop_count unchanged.
- Stuck detection:
  - Stimulus: key_in held at 128'hA5..A5 for 8 sample events with STUCK_LIMIT=8 and the FIFO draining.
  - Required: stuck=1 exactly after the 8th sample edge, not after the 7th.
  - Follow-up: change key_in; stuck remains 1.
- Flush priority:
  - Stimulus: flush=1 coincident with a sample event and key_ready=1, with level=2 and overflow=1.
  - Required: next cycle level=0, key_valid=0, overflow=0, drop_count=0, stuck=0; ph continues counting.
- Asynchronous reset:
  - Stimulus: assert reset between clk edges with level=3.
  - Required: key_valid, level and key_out go to 0 before the next edge.
  - After release with enable=0: no samples are captured until enable=1.
